i2c_reg_slave_driver: RTL and testbench

Parametrised register-file driver for the I2C slave byte engine. It turns the engine's per-byte `received`/`sended` handshakes into register-pointer transactions: a pointer byte, then auto-incrementing multi-byte reads and, optionally, writes. A user-side port updates register contents, such as live sensor values. It replaces the fixed two-command chip-ID/INT16 driver with a generic `REG_COUNT`-deep map.

---
 rtl/i2c_reg_slave_driver.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_reg_slave_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave_driver.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave_driver
//
// Register-file driver that sits behind an I2C slave byte engine. The engine
// reports each received byte with a level on `received` and each transmitted
// and ACKed byte with a level on `sended`. This block turns those handshakes
// into register-pointer transactions:
//   - the first byte after IDLE is the register pointer,
//   - following master reads return reg[ptr] and auto-increment the pointer,
//   - following master writes store into reg[ptr] and auto-increment it
//     (only when I2C_REG_SLAVE_WRITE_EN is defined).
// A user-side write port lets local logic refresh register contents, such as
// live sensor values.
//
// Build option:
//   I2C_REG_SLAVE_WRITE_EN  defined   -> I2C data bytes are written to the map
//                           undefined -> I2C data bytes are discarded,
//                                        wr_strobe / wr_idx are tied to 0
//
// Ports:
//   clk          in   single clock, everything on posedge
//   reset        in   synchronous, active-high
//   address      out  [6:0]  constant SLAVE_ADDRESS for the byte engine
//   datasend     out  [7:0]  byte the engine sends on the next master read
//   sended       in          level; rising edge = datasend shifted out + ACKed
//   datareceive  in   [7:0]  received byte, valid while `received` is high
//   received     in          level; rising edge = new byte in datareceive
//   stop         in          one-cycle pulse on STOP / repeated START
//   ext_we       in          user-side register write enable
//   ext_idx      in   [PTR_W-1:0]  user-side register index
//   ext_wdata    in   [7:0]  user-side write data
//   regs_flat    out  [REG_COUNT*8-1:0]  register i at bits [8i+7:8i]
//   wr_strobe    out         one-cycle pulse when an I2C write commits
//   wr_idx       out  [PTR_W-1:0]  index of the committed I2C write
//   busy         out         high from the pointer byte until `stop`
// ---------------------------------------------------------------------------
module i2c_reg_slave_driver #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h3C,
  parameter int         REG_COUNT     = 8,
  parameter int         PTR_W         = 3,
  parameter logic [7:0] CHIP_ID       = 8'hA5,
  parameter logic [7:0] OOR_DATA      = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [6:0]             address,
  output logic [7:0]             datasend,
  input  logic                   sended,
  input  logic [7:0]             datareceive,
  input  logic                   received,
  input  logic                   stop,
  input  logic                   ext_we,
  input  logic [PTR_W-1:0]       ext_idx,
  input  logic [7:0]             ext_wdata,
  output logic [REG_COUNT*8-1:0] regs_flat,
  output logic                   wr_strobe,
  output logic [PTR_W-1:0]       wr_idx,
  output logic                   busy
);

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oor_q, oor_d;
  logic             received_q, sended_q;
  logic             rx_evt_q, rx_evt_d;
  logic             tx_evt_q, tx_evt_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       datasend_q, datasend_d;
  logic [7:0]       regs_q [REG_COUNT];
  logic [7:0]       regs_d [REG_COUNT];

`ifdef I2C_REG_SLAVE_WRITE_EN
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
`endif

  // Pointer auto-increment; wraps explicitly so non-power-of-two maps work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == REG_COUNT - 1) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Events are registered (together with the received byte) so that all
  // transaction processing happens one cycle after the handshake rises.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    oor_d    = oor_q;
    regs_d   = regs_q;
    rx_evt_d  = received & ~received_q;
    tx_evt_d  = sended & ~sended_q;
    rx_data_d = datareceive;
`ifdef I2C_REG_SLAVE_WRITE_EN
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
`endif

    // A received byte wins over a simultaneous sended event; the sended
    // event is simply dropped (protocol error on the bus side).
    if (rx_evt_q) begin
      if (state_q == ST_IDLE) begin
        ptr_d   = rx_data_q[PTR_W-1:0];
        oor_d   = (int'(rx_data_q) >= REG_COUNT);
        state_d = ST_DATA;
      end else begin
`ifdef I2C_REG_SLAVE_WRITE_EN
        // Out-of-range pointers alias onto real registers through the
        // truncated ptr, so writes are suppressed while oor is set.
        // Register 0 is the read-only chip ID.
        if (!oor_q && (ptr_q != '0)) begin
          regs_d[ptr_q] = rx_data_q;
          wr_strobe_d   = 1'b1;
          wr_idx_d      = ptr_q;
        end
`endif
        ptr_d = ptr_inc(ptr_q);
      end
    end else if (tx_evt_q) begin
      ptr_d = ptr_inc(ptr_q);
    end

    // User-side write is applied last so it overrides a same-index I2C write.
    if (ext_we && (ext_idx != '0) && (int'(ext_idx) < REG_COUNT)) begin
      regs_d[ext_idx] = ext_wdata;
    end
    regs_d[0] = CHIP_ID;

    // stop is handled after any event in the same cycle.
    if (stop) begin
      state_d = ST_IDLE;
    end

    // The outgoing byte follows the next pointer but the current register
    // contents, so a user write shows up two cycles after ext_we.
    if (oor_d) begin
      datasend_d = OOR_DATA;
    end else begin
      datasend_d = regs_q[ptr_d];
    end
  end

  // State, pointer, edge-detect and register-file flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      oor_q      <= 1'b0;
      received_q <= 1'b0;
      sended_q   <= 1'b0;
      rx_evt_q   <= 1'b0;
      tx_evt_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      datasend_q <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (i == 0) ? CHIP_ID : 8'h00;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      oor_q      <= oor_d;
      received_q <= received;
      sended_q   <= sended;
      rx_evt_q   <= rx_evt_d;
      tx_evt_q   <= tx_evt_d;
      rx_data_q  <= rx_data_d;
      datasend_q <= datasend_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef I2C_REG_SLAVE_WRITE_EN
  // Write-commit strobe and index for the user side.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_idx    = wr_idx_q;
`else
  assign wr_strobe = 1'b0;
  assign wr_idx    = '0;
`endif

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign address  = SLAVE_ADDRESS;
  assign datasend = datasend_q;
  assign busy     = (state_q == ST_DATA);

endmodule

// File: tb/tb_i2c_reg_slave_driver.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_slave_driver
//
// Directed testbench for i2c_reg_slave_driver with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the next edge. Expected values are hand-computed; the
// write-enable build option selects the expected register contents.
// ---------------------------------------------------------------------------
module tb_i2c_reg_slave_driver;

  localparam int REG_COUNT = 8;
  localparam int PTR_W     = 3;

`ifdef I2C_REG_SLAVE_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [6:0]             address;
  logic [7:0]             datasend;
  logic                   sended = 1'b0;
  logic [7:0]             datareceive = 8'h00;
  logic                   received = 1'b0;
  logic                   stop = 1'b0;
  logic                   ext_we = 1'b0;
  logic [PTR_W-1:0]       ext_idx = '0;
  logic [7:0]             ext_wdata = 8'h00;
  logic [REG_COUNT*8-1:0] regs_flat;
  logic                   wr_strobe;
  logic [PTR_W-1:0]       wr_idx;
  logic                   busy;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Values captured two cycles after a received rise.
  logic [7:0]       capData;
  logic             capBusy;
  logic             capStrobe;
  logic [PTR_W-1:0] capIdx;

  i2c_reg_slave_driver dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .datasend    (datasend),
    .sended      (sended),
    .datareceive (datareceive),
    .received    (received),
    .stop        (stop),
    .ext_we      (ext_we),
    .ext_idx     (ext_idx),
    .ext_wdata   (ext_wdata),
    .regs_flat   (regs_flat),
    .wr_strobe   (wr_strobe),
    .wr_idx      (wr_idx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] regByte(input int idx);
    return regs_flat[8*idx +: 8];
  endfunction

  // One received byte: rise at cycle N, capture outputs at N+2, then release.
  task automatic applyStimulus(input logic [7:0] b);
    datareceive = b;
    received    = 1'b1;
    tick();
    tick();
    capData   = datasend;
    capBusy   = busy;
    capStrobe = wr_strobe;
    capIdx    = wr_idx;
    received  = 1'b0;
    tick();
  endtask

  // One master read completing: datasend holds the next byte from N+2 on.
  task automatic pulseSended();
    sended = 1'b1;
    tick();
    tick();
    sended = 1'b0;
    tick();
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // User write at cycle N; regs_flat is checked at N+1.
  task automatic extWrite(input logic [PTR_W-1:0] idx, input logic [7:0] data);
    ext_we    = 1'b1;
    ext_idx   = idx;
    ext_wdata = data;
    tick();
    ext_we = 1'b0;
    checkOutput($sformatf("ext_reg%0d", idx), 32'(regByte(int'(idx))), 32'(data));
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_datasend", 32'(datasend), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    checkOutput("rst_reg0", 32'(regByte(0)), 32'hA5);
    checkOutput("rst_reg1", 32'(regByte(1)), 32'h00);
    checkOutput("address", 32'(address), 32'h3C);
    reset = 1'b0;
    tick();

    // Read with no pointer byte: chip ID, then reg1
    checkOutput("nop_read0", 32'(datasend), 32'hA5);
    pulseSended();
    checkOutput("nop_read1", 32'(datasend), 32'h00);
    checkOutput("nop_busy", 32'(busy), 32'h0);

    // User writes, then pointer 3 and two reads
    extWrite(3'd3, 8'h12);
    extWrite(3'd4, 8'h34);
    applyStimulus(8'h03);
    checkOutput("ptr3_busy", 32'(capBusy), 32'h1);
    checkOutput("ptr3_data", 32'(capData), 32'h12);
    checkOutput("ptr3_strobe", 32'(capStrobe), 32'h0);
    pulseSended();
    checkOutput("ptr4_data", 32'(datasend), 32'h34);
    pulseStop();
    checkOutput("stop_busy", 32'(busy), 32'h0);

    // Pointer 6 then three data bytes, wrapping into read-only reg0
    applyStimulus(8'h06);
    applyStimulus(8'hAA);
    checkOutput("wr_strobe", 32'(capStrobe), WRITE_EN ? 32'h1 : 32'h0);
    checkOutput("wr_idx", 32'(capIdx), WRITE_EN ? 32'h6 : 32'h0);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    checkOutput("wr_reg6", 32'(regByte(6)), WRITE_EN ? 32'hAA : 32'h00);
    checkOutput("wr_reg7", 32'(regByte(7)), WRITE_EN ? 32'hBB : 32'h00);
    checkOutput("wr_reg0", 32'(regByte(0)), 32'hA5);
    checkOutput("wr_ptr1_data", 32'(datasend), 32'h00);
    pulseStop();

    // Read wrap from reg7 to reg0
    applyStimulus(8'h07);
    checkOutput("ptr7_data", 32'(capData), WRITE_EN ? 32'hBB : 32'h00);
    pulseSended();
    checkOutput("wrap_data", 32'(datasend), 32'hA5);
    pulseStop();

    // Out-of-range pointer, read, stop mid-read, new pointer 2
    extWrite(3'd2, 8'h5A);
    applyStimulus(8'h20);
    checkOutput("oor_data", 32'(capData), 32'hFF);
    pulseSended();
    checkOutput("oor_read", 32'(datasend), 32'hFF);
    pulseStop();
    checkOutput("oor_stop_busy", 32'(busy), 32'h0);
    checkOutput("oor_held", 32'(datasend), 32'hFF);
    applyStimulus(8'h02);
    checkOutput("ptr2_busy", 32'(capBusy), 32'h1);
    checkOutput("ptr2_data", 32'(capData), 32'h5A);

    // Reset mid-DATA
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_datasend", 32'(datasend), 32'h00);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_wr_strobe", 32'(wr_strobe), 32'h0);
    checkOutput("mid_rst_reg2", 32'(regByte(2)), 32'h00);
    checkOutput("mid_rst_reg3", 32'(regByte(3)), 32'h00);
    checkOutput("mid_rst_reg0", 32'(regByte(0)), 32'hA5);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_data", 32'(datasend), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
